lsu_ctrl: RTL and testbench

Load/store sequencing controller between the Execute stage and the data-memory bus. It captures the registered memory request from Execute (address, read/write byte masks, sign-extend flag, write data) and runs one req/ack transaction on the bus, stalling upstream while busy. It shifts byte lanes to the word-aligned bus and returns aligned, optionally sign-extended load data for register write-back.

---
 rtl/lsu_ctrl.sv | 141 ++++++++++++++
 tb/tb_lsu_ctrl.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: Execute-to-bus load/store sequencer; request to ld_vld in 2+k cycles, stall high while an access is in flight.
// Optional misaligned-access trap compiled in with LSU_MISALIGN_TRAP_EN.
module lsu_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ex_MEMaddr,
    input  logic [3:0]  ex_MEMrden,
    input  logic        ex_MEMrden_SEXT,
    input  logic [3:0]  ex_MEMwren,
    input  logic [31:0] ex_MEMwrdata,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        ld_vld,
    output logic [31:0] ld_data,
    output logic        bus_err,
    output logic        misalign_err
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
`ifdef LSU_MISALIGN_TRAP_EN
    localparam logic [1:0] S_ERR  = 2'd2;
`endif

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    logic [1:0]  state;
    logic [31:0] tcnt;
    logic [1:0]  off_q;
    logic [1:0]  size_q;
    logic        sext_q;

    logic        wr_sel;
    logic        req_vld;
    logic [3:0]  mask;
    logic [1:0]  off;
    logic [1:0]  size;
    logic        timeout_hit;
    logic [31:0] rd_sh;
    logic [31:0] ld_next;

    assign wr_sel  = |ex_MEMwren;
    assign req_vld = wr_sel | (|ex_MEMrden);
    assign mask    = wr_sel ? ex_MEMwren : ex_MEMrden;
    assign off     = ex_MEMaddr[1:0];
    assign size    = mask[3] ? SZ_WORD : (mask[1] ? SZ_HALF : SZ_BYTE);

    // TIMEOUT of 0 means wait for ack forever
    assign timeout_hit = (TIMEOUT != 0) && (tcnt == TIMEOUT);

    assign stall   = (state != S_IDLE);
    assign mem_req = (state == S_REQ);

`ifdef LSU_MISALIGN_TRAP_EN
    logic misaligned;
    assign misaligned   = ((size == SZ_WORD) && (off != 2'd0)) ||
                          ((size == SZ_HALF) && off[0]);
    assign misalign_err = (state == S_ERR);
`else
    assign misalign_err = 1'b0;
`endif

    assign rd_sh = mem_rdata >> {off_q, 3'b000};

    always_comb begin
        ld_next = rd_sh;
        if (size_q == SZ_HALF) begin
            ld_next = {{16{sext_q & rd_sh[15]}}, rd_sh[15:0]};
        end else if (size_q == SZ_BYTE) begin
            ld_next = {{24{sext_q & rd_sh[7]}}, rd_sh[7:0]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            tcnt      <= '0;
            off_q     <= '0;
            size_q    <= SZ_BYTE;
            sext_q    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= '0;
            mem_wdata <= '0;
            ld_vld    <= 1'b0;
            ld_data   <= '0;
            bus_err   <= 1'b0;
        end else begin
            ld_vld  <= 1'b0;
            bus_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_vld) begin
`ifdef LSU_MISALIGN_TRAP_EN
                        if (misaligned) begin
                            state <= S_ERR;
                        end else begin
`endif
                            state     <= S_REQ;
                            tcnt      <= '0;
                            off_q     <= off;
                            size_q    <= size;
                            sext_q    <= ex_MEMrden_SEXT;
                            mem_we    <= wr_sel;
                            mem_addr  <= {ex_MEMaddr[31:2], 2'b00};
                            mem_be    <= mask << off;
                            mem_wdata <= ex_MEMwrdata << {off, 3'b000};
`ifdef LSU_MISALIGN_TRAP_EN
                        end
`endif
                    end
                end
                S_REQ: begin
                    // an ack in the final timeout cycle still completes the access
                    if (mem_ack) begin
                        state <= S_IDLE;
                        if (!mem_we) begin
                            ld_vld  <= 1'b1;
                            ld_data <= ld_next;
                        end
                    end else if (timeout_hit) begin
                        state   <= S_IDLE;
                        bus_err <= 1'b1;
                    end else if (tcnt != 32'hFFFF_FFFF) begin
                        tcnt <= tcnt + 32'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl with a transaction-level reference model checked every cycle.
module tb_lsu_ctrl;
    localparam int TMO = 4;
`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic [31:0] ex_MEMaddr;
    logic [3:0]  ex_MEMrden;
    logic        ex_MEMrden_SEXT;
    logic [3:0]  ex_MEMwren;
    logic [31:0] ex_MEMwrdata;
    logic        stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        ld_vld;
    logic [31:0] ld_data;
    logic        bus_err;
    logic        misalign_err;

    lsu_ctrl #(.TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .ex_MEMaddr(ex_MEMaddr), .ex_MEMrden(ex_MEMrden),
        .ex_MEMrden_SEXT(ex_MEMrden_SEXT), .ex_MEMwren(ex_MEMwren),
        .ex_MEMwrdata(ex_MEMwrdata),
        .stall(stall), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .ld_vld(ld_vld), .ld_data(ld_data),
        .bus_err(bus_err), .misalign_err(misalign_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference: at most one outstanding transaction, described by what the bus must show
    bit          m_busy = 1'b0;
    bit          m_trap = 1'b0;
    bit          m_we = 1'b0;
    bit          m_ld_vld = 1'b0;
    bit          m_bus_err = 1'b0;
    bit          m_sext = 1'b0;
    int          cyc = 0;
    int          t_req = 0;
    int          m_off = 0;
    logic [3:0]  m_rmask = 4'd0;
    logic [3:0]  m_be = 4'd0;
    logic [31:0] m_addr = 32'd0;
    logic [31:0] m_wdata = 32'd0;
    logic [31:0] m_ld_data = 32'd0;

    function automatic logic [31:0] ld_model(input logic [31:0] rd, input int off,
                                             input logic [3:0] rmask, input bit sext);
        logic [31:0] v;
        v = rd >> (8 * off);
        if (rmask[3]) return v;
        if (rmask[1]) begin
            v = v % 32'h1_0000;
            if (sext && v >= 32'h8000) v = v + 32'hFFFF_0000;
            return v;
        end
        v = v % 32'h100;
        if (sext && v >= 32'h80) v = v + 32'hFFFF_FF00;
        return v;
    endfunction

    function automatic bit misaligned(input logic [3:0] m, input int off);
        if (m[3]) return TRAP && (off != 0);
        if (m[1]) return TRAP && (off % 2 == 1);
        return 1'b0;
    endfunction

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_busy = 0; m_trap = 0; m_we = 0; m_ld_vld = 0; m_bus_err = 0;
                m_be = 0; m_addr = 0; m_wdata = 0; m_ld_data = 0; cyc = 0;
            end else begin
                logic [3:0] mk;
                int         of;
                cyc = cyc + 1;
                m_ld_vld = 0;
                m_bus_err = 0;
                if (m_trap) begin
                    m_trap = 0;
                end else if (m_busy) begin
                    if (mem_ack) begin
                        m_busy = 0;
                        if (!m_we) begin
                            m_ld_vld = 1;
                            m_ld_data = ld_model(mem_rdata, m_off, m_rmask, m_sext);
                        end
                    end else if (TMO != 0 && cyc == t_req + 1 + TMO) begin
                        m_busy = 0;
                        m_bus_err = 1;
                    end
                end else if (ex_MEMrden != 0 || ex_MEMwren != 0) begin
                    mk = (ex_MEMwren != 0) ? ex_MEMwren : ex_MEMrden;
                    of = int'(ex_MEMaddr % 4);
                    if (misaligned(mk, of)) begin
                        m_trap = 1;
                    end else begin
                        m_busy  = 1;
                        t_req   = cyc;
                        m_we    = (ex_MEMwren != 0);
                        m_addr  = ex_MEMaddr - (ex_MEMaddr % 4);
                        m_be    = 4'((int'(mk) << of) % 16);
                        m_wdata = ex_MEMwrdata << (8 * of);
                        m_off   = of;
                        m_rmask = ex_MEMrden;
                        m_sext  = ex_MEMrden_SEXT;
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            chk("stall", 32'(stall), 32'(m_busy | m_trap));
            chk("mem_req", 32'(mem_req), 32'(m_busy));
            chk("ld_vld", 32'(ld_vld), 32'(m_ld_vld));
            chk("ld_data", ld_data, m_ld_data);
            chk("bus_err", 32'(bus_err), 32'(m_bus_err));
            chk("misalign_err", 32'(misalign_err), 32'(m_trap));
            if (m_busy) begin
                chk("mem_we", 32'(mem_we), 32'(m_we));
                chk("mem_addr", mem_addr, m_addr);
                chk("mem_be", 32'(mem_be), 32'(m_be));
                chk("mem_wdata", mem_wdata, m_wdata);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // presents a request for one cycle T; returns 1ns into T+1
    task automatic issue(input logic [31:0] a, input logic [3:0] rd, input logic sx,
                         input logic [3:0] wr, input logic [31:0] wd);
        ex_MEMaddr = a; ex_MEMrden = rd; ex_MEMrden_SEXT = sx;
        ex_MEMwren = wr; ex_MEMwrdata = wd;
        step(1);
        ex_MEMaddr = 0; ex_MEMrden = 0; ex_MEMrden_SEXT = 0;
        ex_MEMwren = 0; ex_MEMwrdata = 0;
    endtask

    task automatic ack(input logic [31:0] d);
        mem_ack = 1'b1; mem_rdata = d;
        step(1);
        mem_ack = 1'b0; mem_rdata = 32'h0;
    endtask

    initial begin
        rst = 1'b1;
        mem_ack = 0; mem_rdata = 0;
        ex_MEMaddr = 0; ex_MEMrden = 0; ex_MEMrden_SEXT = 0; ex_MEMwren = 0; ex_MEMwrdata = 0;
        step(2);
        chk("rst_stall", 32'(stall), 32'h0);
        chk("rst_mem_req", 32'(mem_req), 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_ld_data", ld_data, 32'h0);
        rst = 1'b0;
        step(1);

        issue(32'h100, 4'b1111, 1'b0, 4'b0000, 32'h0);
        chk("w_ld_req", 32'(mem_req), 32'h1);
        chk("w_ld_be", 32'(mem_be), 32'hF);
        chk("w_ld_addr", mem_addr, 32'h100);
        ack(32'hDEAD_BEEF);
        chk("w_ld_vld", 32'(ld_vld), 32'h1);
        chk("w_ld_data", ld_data, 32'hDEAD_BEEF);
        chk("w_ld_req_low", 32'(mem_req), 32'h0);

        issue(32'h103, 4'b0001, 1'b1, 4'b0000, 32'h0);
        chk("b_ld_be", 32'(mem_be), 32'h8);
        chk("b_ld_stall_t1", 32'(stall), 32'h1);
        step(3);
        chk("b_ld_stall_t4", 32'(stall), 32'h1);
        ack(32'h80FF_1234);
        chk("b_ld_sext", ld_data, 32'hFFFF_FF80);
        chk("b_ld_stall_t5", 32'(stall), 32'h0);
        issue(32'h103, 4'b0001, 1'b0, 4'b0000, 32'h0);
        ack(32'h80FF_1234);
        chk("b_ld_zext", ld_data, 32'h0000_0080);

        issue(32'h202, 4'b0000, 1'b0, 4'b0011, 32'h0000_ABCD);
        chk("h_st_we", 32'(mem_we), 32'h1);
        chk("h_st_be", 32'(mem_be), 32'hC);
        chk("h_st_wdata", mem_wdata, 32'hABCD_0000);
        ack(32'hFFFF_FFFF);
        chk("h_st_no_ld", 32'(ld_vld), 32'h0);
        chk("h_st_ld_hold", ld_data, 32'h0000_0080);

        issue(32'h300, 4'b1111, 1'b0, 4'b0001, 32'h0000_005A);
        chk("prio_we", 32'(mem_we), 32'h1);
        chk("prio_be", 32'(mem_be), 32'h1);
        ack(32'h1111_1111);
        chk("prio_no_ld", 32'(ld_vld), 32'h0);

        issue(32'h102, 4'b0011, 1'b1, 4'b0000, 32'h0);
        chk("h_ld_be", 32'(mem_be), 32'hC);
        ack(32'h8001_0000);
        chk("h_ld_sext", ld_data, 32'hFFFF_8001);

        issue(32'h400, 4'b1111, 1'b0, 4'b0000, 32'h0);
        step(4);
        chk("tmo_no_err_t5", 32'(bus_err), 32'h0);
        chk("tmo_req_t5", 32'(mem_req), 32'h1);
        step(1);
        chk("tmo_err_t6", 32'(bus_err), 32'h1);
        chk("tmo_req_low_t6", 32'(mem_req), 32'h0);
        chk("tmo_stall_low_t6", 32'(stall), 32'h0);
        step(2);
        ack(32'h5555_5555);
        chk("late_ack_no_ld", 32'(ld_vld), 32'h0);
        issue(32'h100, 4'b1111, 1'b0, 4'b0000, 32'h0);
        ack(32'hCAFE_F00D);
        chk("after_tmo_ld", ld_data, 32'hCAFE_F00D);

        issue(32'h104, 4'b1111, 1'b0, 4'b0000, 32'h0);
        step(1);
        #1 rst = 1'b1;
        #1;
        chk("arst_req", 32'(mem_req), 32'h0);
        chk("arst_stall", 32'(stall), 32'h0);
        #1 rst = 1'b0;
        step(1);
        ack(32'h7777_7777);
        chk("arst_no_ld", 32'(ld_vld), 32'h0);
        chk("arst_no_err", 32'(bus_err), 32'h0);

        issue(32'h101, 4'b1111, 1'b0, 4'b0000, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
        chk("mis_err", 32'(misalign_err), 32'h1);
        chk("mis_no_req", 32'(mem_req), 32'h0);
        chk("mis_stall", 32'(stall), 32'h1);
        step(1);
        chk("mis_err_done", 32'(misalign_err), 32'h0);
        chk("mis_stall_done", 32'(stall), 32'h0);
`else
        chk("mis_be", 32'(mem_be), 32'hE);
        chk("mis_addr", mem_addr, 32'h100);
        ack(32'h1122_3344);
        chk("mis_ld", ld_data, 32'h0011_2233);
`endif
        step(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
